// File: rtl/fvf_pkg.sv
// Shared definitions for the filter vector fetcher: FSM states, default
// geometry and the filter RAM address mapping.
package fvf_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_NUM_VEC = 4;
  localparam int DEF_VEC_LEN = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRAIN  = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } fvf_state_e;

  // Vector v, element k lives at base + v*vec_len + k; caller truncates to
  // the RAM address width, which gives the required wrap-around.
  function automatic int unsigned fvf_addr(input int unsigned base,
                                           input int unsigned v,
                                           input int unsigned k,
                                           input int unsigned vec_len);
    return base + v * vec_len + k;
  endfunction

endpackage

// File: rtl/fvf_cache.sv
// NUM_VEC x VEC_LEN filter cache: one write port, parallel read of element
// rd_idx across every vector.
module fvf_cache
  import fvf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_VEC = DEF_NUM_VEC,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int VW      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  parameter int KW      = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [VW-1:0]                     wr_vec,
  input  logic [KW-1:0]                     wr_idx,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic [KW-1:0]                     rd_idx,
  output logic [NUM_VEC-1:0][DATA_W-1:0]    rd_data
);

  for (genvar v = 0; v < NUM_VEC; v++) begin : g_vec
    logic [DATA_W-1:0] mem [VEC_LEN];

    always_ff @(posedge clk) begin
      if (we && wr_vec == VW'(v))
        mem[wr_idx] <= wr_data;
    end

    assign rd_data[v] = mem[rd_idx];
  end

endmodule

// File: rtl/filter_vector_fetcher.sv
// Fetches NUM_VEC filter vectors from the filter RAM into a local cache and
// streams element k of all vectors in parallel; repeat passes replay the cache.
module filter_vector_fetcher
  import fvf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_VEC = DEF_NUM_VEC,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        reload,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        cache_valid,
  output logic [ADDR_W-1:0]           dut__bvm__address,
  output logic                        dut__bvm__enable,
  output logic                        dut__bvm__write,
  output logic [DATA_W-1:0]           dut__bvm__data,
  input  logic [DATA_W-1:0]           bvm__dut__data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_VEC*DATA_W-1:0]   out_elements,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last
);

  localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(VEC_LEN - 1);
  localparam logic [VW-1:0]    V_LAST = VW'(NUM_VEC - 1);

  fvf_state_e state;

  logic [ADDR_W-1:0] base_q, cached_base_q, addr_q;
  logic              cache_valid_q;
  logic [VW-1:0]     iss_v, cap_v, nxt_v;
  logic [IDX_W-1:0]  iss_k, cap_k, nxt_k, k_q;
  logic              cap_vld, iss_last, hit;

  logic [NUM_VEC-1:0][DATA_W-1:0] rd_data;

  // Walk (vector, element) of the read currently on the bus.
  always_comb begin
    nxt_k = iss_k + IDX_W'(1);
    nxt_v = iss_v;
    if (iss_k == K_LAST) begin
      nxt_k = '0;
      nxt_v = iss_v + VW'(1);
    end
    iss_last = (iss_v == V_LAST) && (iss_k == K_LAST);
  end

  assign hit = cache_valid_q && !reload && (base_addr == cached_base_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      base_q        <= '0;
      cached_base_q <= '0;
      cache_valid_q <= 1'b0;
      addr_q        <= '0;
      iss_v         <= '0;
      iss_k         <= '0;
      cap_vld       <= 1'b0;
      cap_v         <= '0;
      cap_k         <= '0;
      k_q           <= '0;
    end else begin
      // Read data returns one cycle after the address; remember its slot.
      cap_vld <= (state == FETCH);
      cap_v   <= iss_v;
      cap_k   <= iss_k;

      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            k_q    <= '0;
            if (hit) begin
              state <= STREAM;
            end else begin
              state         <= FETCH;
              cache_valid_q <= 1'b0;
              addr_q        <= base_addr;
              iss_v         <= '0;
              iss_k         <= '0;
            end
          end
        end
        FETCH: begin
          if (iss_last) begin
            state <= DRAIN;
          end else begin
            iss_v  <= nxt_v;
            iss_k  <= nxt_k;
            addr_q <= ADDR_W'(fvf_addr(32'(base_q), 32'(nxt_v), 32'(nxt_k),
                                       32'(VEC_LEN)));
          end
        end
        DRAIN: begin
          cached_base_q <= base_q;
          cache_valid_q <= 1'b1;
          state         <= STREAM;
        end
        STREAM: begin
          if (out_ready) begin
            if (k_q == K_LAST) begin
              state <= DONE;
              k_q   <= '0;
            end else begin
              k_q <= k_q + IDX_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fvf_cache #(
    .DATA_W  (DATA_W),
    .NUM_VEC (NUM_VEC),
    .VEC_LEN (VEC_LEN),
    .VW      (VW),
    .KW      (IDX_W)
  ) u_cache (
    .clk     (clk),
    .we      (cap_vld),
    .wr_vec  (cap_v),
    .wr_idx  (cap_k),
    .wr_data (bvm__dut__data),
    .rd_idx  (k_q),
    .rd_data (rd_data)
  );

  assign busy              = (state != IDLE);
  assign done              = (state == DONE);
  assign out_valid         = (state == STREAM);
  assign out_index         = k_q;
  assign out_last          = out_valid && (k_q == K_LAST);
  // Cache contents are undefined after reset, so keep the bus quiet when idle.
  assign out_elements      = out_valid ? rd_data : '0;
  assign cache_valid       = cache_valid_q;
  assign dut__bvm__address = addr_q;
  assign dut__bvm__enable  = (state == FETCH);
  assign dut__bvm__write   = 1'b0;
  assign dut__bvm__data    = '0;

endmodule

// File: tb/tb_filter_vector_fetcher.sv
// Randomized self-checking bench for filter_vector_fetcher against a
// cache-snapshot reference model of the filter RAM.
module tb_filter_vector_fetcher;

  localparam int NV = 4, VL = 9, DW = 16, AW = 9, TOT = NV * VL;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, reload = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic busy, done, cache_valid, bvm_en, bvm_we, out_valid, out_last;
  logic [AW-1:0] bvm_addr;
  logic [DW-1:0] bvm_wdata, bvm_rdata = '0;
  logic [NV*DW-1:0] out_elements;
  logic [3:0] out_index;

  logic [DW-1:0] ram [0:511];

  int checks = 0, errors = 0;

  // reference model: snapshot of what the cache should hold
  logic [DW-1:0] mc [NV][VL];
  logic [AW-1:0] m_base = '0;
  bit m_valid = 0;

  // observations from one pass
  int addr_o[$];
  logic [NV*DW-1:0] el_o[$];
  int idx_o[$];
  bit last_o[$];
  int en_first, en_last, valid_first, done_cyc, done_cnt, stall_bad, wr_bad;
  bit timeout;

  filter_vector_fetcher dut (
    .clk(clk), .reset(reset), .start(start), .reload(reload),
    .base_addr(base_addr), .busy(busy), .done(done), .cache_valid(cache_valid),
    .dut__bvm__address(bvm_addr), .dut__bvm__enable(bvm_en),
    .dut__bvm__write(bvm_we), .dut__bvm__data(bvm_wdata),
    .bvm__dut__data(bvm_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_elements(out_elements), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bvm_en) bvm_rdata <= ram[bvm_addr];

  function automatic logic [NV*DW-1:0] exp_el(input int k);
    logic [NV*DW-1:0] r;
    for (int v = 0; v < NV; v++) r[v*DW +: DW] = mc[v][k];
    return r;
  endfunction

  task automatic model_pass(input logic [AW-1:0] b, input bit rl, output bit ef);
    ef = rl || !m_valid || (b != m_base);
    if (ef) begin
      for (int v = 0; v < NV; v++)
        for (int k = 0; k < VL; k++)
          mc[v][k] = ram[(int'(b) + v * VL + k) % 512];
      m_base  = b;
      m_valid = 1;
    end
  endtask

  // Drive one start and record everything the DUT does until done settles.
  // mode 0: ready always high; 1: stall 5 cycles at k=3 then toggle; 2: random.
  task automatic do_pass(input logic [AW-1:0] b, input bit rl, input int mode, input bit poke);
    logic [NV*DW-1:0] p_el;
    int p_idx, cyc, stall_n;
    bit p_last, p_stall, tog;
    addr_o.delete(); el_o.delete(); idx_o.delete(); last_o.delete();
    en_first = -1; en_last = -1; valid_first = -1; done_cyc = -1;
    done_cnt = 0; stall_bad = 0; wr_bad = 0; timeout = 0;
    p_el = '0; p_idx = 0; p_last = 0; p_stall = 0; tog = 0; stall_n = 0; cyc = 0;
    @(negedge clk);
    start = 1; base_addr = b; reload = rl; out_ready = 1;
    @(posedge clk);
    #1 start = 0; reload = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (poke && (cyc == 10 || (valid_first > 0 && cyc == valid_first + 2))) begin
        start = 1; base_addr = 9'h055; reload = 1;
      end else begin
        start = 0; reload = 0;
      end
      if (bvm_we !== 1'b0 || bvm_wdata !== '0) wr_bad++;
      if (bvm_en) begin
        addr_o.push_back(int'(bvm_addr));
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
      end
      if (out_valid && valid_first < 0) valid_first = cyc;
      if (p_stall && (out_elements !== p_el || int'(out_index) != p_idx || out_last !== p_last))
        stall_bad++;
      case (mode)
        0: out_ready = 1;
        1: begin
          if (stall_n < 5 && out_valid && out_index == 4'd3) begin
            out_ready = 0; stall_n++;
          end else if (stall_n >= 5) begin
            tog = !tog; out_ready = tog;
          end else out_ready = 1;
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (out_valid && out_ready) begin
        el_o.push_back(out_elements);
        idx_o.push_back(int'(out_index));
        last_o.push_back(out_last);
      end
      p_stall = out_valid && !out_ready;
      p_el = out_elements; p_idx = int'(out_index); p_last = out_last;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
      if (cyc >= 300) begin timeout = 1; break; end
    end
    start = 0; reload = 0; out_ready = 1;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, cache_valid, bvm_en, bvm_addr, out_valid, out_index, out_last, out_elements} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b cv=%b en=%b addr=%h ov=%b idx=%h last=%b el=%h required all zero",
               busy, done, cache_valid, bvm_en, bvm_addr, out_valid, out_index, out_last, out_elements);
    end
    reset = 0;
  endtask

  task automatic test_cold_fetch;
    bit ef;
    int bad;
    for (int i = 0; i < 512; i++) ram[i] = DW'(16'h0100 + i);
    model_pass(9'h000, 0, ef);
    do_pass(9'h000, 0, 0, 0);
    checks++;
    if (timeout) begin errors++; $display("FAIL cold_timeout pass did not finish"); end
    bad = 0;
    for (int i = 0; i < addr_o.size(); i++) if (addr_o[i] != i) bad++;
    checks++;
    if (addr_o.size() != TOT || bad != 0) begin
      errors++; $display("FAIL cold_addr count=%0d bad=%0d required count=%0d bad=0", addr_o.size(), bad, TOT);
    end
    checks++;
    if (en_first != 1 || en_last != TOT) begin
      errors++; $display("FAIL cold_en_window got %0d..%0d required 1..%0d", en_first, en_last, TOT);
    end
    checks++;
    if (valid_first != TOT + 2) begin
      errors++; $display("FAIL cold_valid_cycle got %0d required %0d", valid_first, TOT + 2);
    end
    checks++;
    if (el_o.size() < VL || el_o[0] !== 64'h011B_0112_0109_0100 || el_o[VL-1] !== 64'h0123_011A_0111_0108) begin
      errors++; $display("FAIL cold_k0_k8 handshakes=%0d", el_o.size());
    end
    bad = 0;
    for (int i = 0; i < el_o.size(); i++)
      if (el_o[i] !== exp_el(i) || idx_o[i] != i || last_o[i] != (i == VL - 1)) bad++;
    checks++;
    if (el_o.size() != VL || bad != 0) begin
      errors++; $display("FAIL cold_stream handshakes=%0d bad=%0d required %0d and 0", el_o.size(), bad, VL);
    end
    checks++;
    if (done_cyc != TOT + 11 || done_cnt != 1) begin
      errors++; $display("FAIL cold_done cycle=%0d count=%0d required %0d and 1", done_cyc, done_cnt, TOT + 11);
    end
    checks++;
    if (cache_valid !== 1'b1 || wr_bad != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL cold_after cv=%b wr_bad=%0d busy=%b required 1 0 0", cache_valid, wr_bad, busy);
    end
  endtask

  task automatic test_cache_hit;
    bit ef;
    int bad;
    model_pass(9'h000, 0, ef);
    do_pass(9'h000, 0, 0, 0);
    checks++;
    if (addr_o.size() != (ef ? TOT : 0) || valid_first != 1) begin
      errors++; $display("FAIL hit_no_fetch reads=%0d valid_cycle=%0d required 0 and 1", addr_o.size(), valid_first);
    end
    bad = 0;
    for (int i = 0; i < el_o.size(); i++) if (el_o[i] !== exp_el(i) || idx_o[i] != i) bad++;
    checks++;
    if (el_o.size() != VL || bad != 0 || done_cyc != VL + 1) begin
      errors++; $display("FAIL hit_stream handshakes=%0d bad=%0d done=%0d required %0d 0 %0d",
                         el_o.size(), bad, done_cyc, VL, VL + 1);
    end
  endtask

  task automatic test_reload;
    bit ef;
    int bad;
    model_pass(9'h000, 1, ef);
    do_pass(9'h000, 1, 0, 0);
    checks++;
    if (addr_o.size() != TOT) begin
      errors++; $display("FAIL reload_fetch reads=%0d required %0d", addr_o.size(), TOT);
    end
    bad = 0;
    for (int i = 0; i < el_o.size(); i++) if (el_o[i] !== exp_el(i)) bad++;
    checks++;
    if (el_o.size() != VL || bad != 0) begin
      errors++; $display("FAIL reload_stream handshakes=%0d bad=%0d", el_o.size(), bad);
    end
  endtask

  task automatic test_wrap;
    bit ef;
    int bad;
    model_pass(9'h1F0, 0, ef);
    do_pass(9'h1F0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < addr_o.size(); i++) if (addr_o[i] != (16'h1F0 + i) % 512) bad++;
    checks++;
    if (addr_o.size() != TOT || bad != 0 || addr_o[15] != 'h1FF || addr_o[16] != 0 || addr_o[TOT-1] != 'h013) begin
      errors++; $display("FAIL wrap_addr reads=%0d bad=%0d", addr_o.size(), bad);
    end
    bad = 0;
    for (int i = 0; i < el_o.size(); i++) if (el_o[i] !== exp_el(i)) bad++;
    checks++;
    if (el_o.size() != VL || bad != 0 || cache_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_stream handshakes=%0d bad=%0d cv=%b", el_o.size(), bad, cache_valid);
    end
  endtask

  task automatic test_backpressure;
    bit ef;
    int bad;
    model_pass(9'h1F0, 0, ef);
    do_pass(9'h1F0, 0, 1, 0);
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL bp_stable changes_while_stalled=%0d required 0", stall_bad);
    end
    bad = 0;
    for (int i = 0; i < el_o.size(); i++)
      if (el_o[i] !== exp_el(i) || idx_o[i] != i || last_o[i] != (i == VL - 1)) bad++;
    checks++;
    if (el_o.size() != VL || bad != 0) begin
      errors++; $display("FAIL bp_stream handshakes=%0d bad=%0d required %0d 0", el_o.size(), bad, VL);
    end
    checks++;
    if (done_cyc != 20 || done_cnt != 1) begin
      errors++; $display("FAIL bp_done cycle=%0d count=%0d required 20 and 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_reset_mid_fetch;
    bit ef, found;
    int bad;
    model_pass(9'h000, 1, ef);
    found = 0;
    @(negedge clk);
    start = 1; base_addr = 9'h000; reload = 1;
    @(posedge clk);
    #1 start = 0; reload = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (bvm_en && bvm_addr == 9'd20) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_mid_reach address 20 never issued"); end
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    m_valid = 0;
    checks++;
    if ({busy, done, cache_valid, bvm_en, bvm_addr, out_valid, out_index, out_last, out_elements} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs busy=%b cv=%b en=%b addr=%h ov=%b required all zero",
               busy, cache_valid, bvm_en, bvm_addr, out_valid);
    end
    reset = 0;
    model_pass(9'h000, 0, ef);
    do_pass(9'h000, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < el_o.size(); i++) if (el_o[i] !== exp_el(i)) bad++;
    checks++;
    if (addr_o.size() != TOT || el_o.size() != VL || bad != 0) begin
      errors++; $display("FAIL rst_mid_refetch reads=%0d handshakes=%0d bad=%0d required %0d %0d 0",
                         addr_o.size(), el_o.size(), bad, TOT, VL);
    end
  endtask

  task automatic test_ignored_start;
    bit ef;
    model_pass(9'h000, 1, ef);
    do_pass(9'h000, 1, 0, 1);
    checks++;
    if (addr_o.size() != TOT || el_o.size() != VL || done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_start reads=%0d handshakes=%0d dones=%0d busy=%b required %0d %0d 1 0",
                         addr_o.size(), el_o.size(), done_cnt, busy, TOT, VL);
    end
    model_pass(9'h000, 0, ef);
    do_pass(9'h000, 0, 0, 0);
    checks++;
    if (addr_o.size() != (ef ? TOT : 0) || el_o.size() != VL || el_o[0] !== exp_el(0)) begin
      errors++; $display("FAIL ign_cache_kept reads=%0d handshakes=%0d", addr_o.size(), el_o.size());
    end
  endtask

  task automatic test_random;
    bit ef, rl;
    logic [AW-1:0] b;
    int bad;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 512; i++) ram[i] = DW'($urandom);
      case ($urandom_range(0, 2))
        0:       b = m_base;
        1:       b = AW'($urandom_range(500, 511));
        default: b = AW'($urandom);
      endcase
      rl = ($urandom_range(0, 3) == 0);
      model_pass(b, rl, ef);
      do_pass(b, rl, 2, 0);
      bad = 0;
      for (int i = 0; i < addr_o.size(); i++) if (addr_o[i] != (int'(b) + i) % 512) bad++;
      checks++;
      if (timeout || addr_o.size() != (ef ? TOT : 0) || bad != 0) begin
        errors++; $display("FAIL rand_fetch it=%0d base=%h reads=%0d bad=%0d required %0d 0",
                           it, b, addr_o.size(), bad, ef ? TOT : 0);
      end
      bad = 0;
      for (int i = 0; i < el_o.size(); i++)
        if (el_o[i] !== exp_el(i) || idx_o[i] != i || last_o[i] != (i == VL - 1)) bad++;
      checks++;
      if (el_o.size() != VL || bad != 0 || done_cnt != 1 || stall_bad != 0) begin
        errors++; $display("FAIL rand_stream it=%0d handshakes=%0d bad=%0d dones=%0d stall_bad=%0d",
                           it, el_o.size(), bad, done_cnt, stall_bad);
      end
    end
  endtask

  initial begin
    test_reset;
    test_cold_fetch;
    test_cache_hit;
    test_reload;
    test_wrap;
    test_backpressure;
    test_reset_mid_fetch;
    test_ignored_start;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
